// File: rtl/slot_bus_arbiter.sv
// slot_bus_arbiter: round-robin sequencer that shares the single slot register bus
// between NREQ requesters, serialising one access at a time and routing the
// completion (read data / ack) back to the requester that owns the access.
//
// Optional build macro ARB_TIMEOUT_EN: adds a bus watchdog that aborts an access
// after TIMEOUT cycles in CMD/WAIT, answering with rsp_err=1 and rsp_rdata=16'hDEAD.
// Without the macro the arbiter waits indefinitely and rsp_err is tied low.
module slot_bus_arbiter #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [2:0]               grant_id,
    output logic                     bus_cmd_valid,
    input  logic                     bus_cmd_ready,
    output logic                     bus_we,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_wdata,
    input  logic                     bus_rsp_valid,
    input  logic [DATA_W-1:0]        bus_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Requester index is carried in a 3-bit field, so at most 8 requesters fit.
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("slot_bus_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
    end

    logic [1:0]             state;
    logic [2:0]             ptr;
    logic [3:0]             pick_res;
    logic                   any_req;
    logic [2:0]             pick;
    logic [NREQ-1:0]        we_sh;
    logic [NREQ*ADDR_W-1:0] addr_sh;
    logic [NREQ*DATA_W-1:0] wdata_sh;
    logic [NREQ-1:0]        grant_oh;
    logic [NREQ-1:0]        pick_oh;
    logic                   done_ok;
    logic                   abort;
    logic                   expire;

    // Round-robin search: first requester set, starting just after the last owner
    // and wrapping around. Returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] v, input logic [2:0] p);
        logic [3:0]      res;
        logic [NREQ-1:0] sh;
        int              idx;
        res = 4'd0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(p) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            sh = v >> idx;
            if (!res[3] && sh[0]) res = {1'b1, idx[2:0]};
        end
        return res;
    endfunction

    assign pick_res = rr_pick(req_valid, ptr);
    assign any_req  = pick_res[3];
    assign pick     = pick_res[2:0];

    // Bring the chosen requester's fields down to bit 0 so they can be sliced.
    assign we_sh    = req_we >> pick;
    assign addr_sh  = req_addr >> (int'(pick) * ADDR_W);
    assign wdata_sh = req_wdata >> (int'(pick) * DATA_W);

    assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
    assign pick_oh  = {{(NREQ-1){1'b0}}, 1'b1} << pick;

    // A write completes on command accept; a read completes when data returns.
    assign done_ok = (state == ST_CMD  && bus_cmd_ready && bus_we) ||
                     (state == ST_WAIT && bus_rsp_valid);

    // Watchdog only fires when nothing useful happened this cycle, so a
    // completion (or read accept) on the expiry cycle takes precedence.
    assign abort = expire && ((state == ST_CMD  && !bus_cmd_ready) ||
                              (state == ST_WAIT && !bus_rsp_valid));

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    logic [CNT_W-1:0] cnt;
    logic             err_q;

    assign expire  = (state != ST_IDLE) && (cnt >= CNT_W'(TIMEOUT - 1));
    assign rsp_err = err_q;

    // Watchdog counter: zero while idle, counts every cycle an access is open.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (state == ST_IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Error flag is updated only alongside rsp_valid and held until the next one.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            err_q <= 1'b0;
        end else if (done_ok) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Access sequencer: IDLE -> CMD -> (WAIT for reads) -> IDLE.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            ptr           <= 3'(NREQ - 1);
            grant_id      <= 3'd0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            bus_cmd_valid <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            if (done_ok) begin
                bus_cmd_valid <= 1'b0;
                rsp_valid     <= grant_oh;
                rsp_rdata     <= bus_we ? '0 : bus_rdata;
                state         <= ST_IDLE;
            end else if (abort) begin
                bus_cmd_valid <= 1'b0;
                rsp_valid     <= grant_oh;
                rsp_rdata     <= DATA_W'(16'hDEAD);
                state         <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (any_req) begin
                            state         <= ST_CMD;
                            ptr           <= pick;
                            grant_id      <= pick;
                            req_ready     <= pick_oh;
                            bus_cmd_valid <= 1'b1;
                            bus_we        <= we_sh[0];
                            bus_addr      <= addr_sh[ADDR_W-1:0];
                            bus_wdata     <= wdata_sh[DATA_W-1:0];
                        end
                    end
                    ST_CMD: begin
                        if (bus_cmd_ready) begin
                            bus_cmd_valid <= 1'b0;
                            state         <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                    end
                    default: begin
                        bus_cmd_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slot_bus_arbiter.sv
// Directed bench for slot_bus_arbiter (NREQ=2). Inputs change on the falling edge,
// outputs are checked on the falling edge, half a cycle after the active edge.
module tb_slot_bus_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic [2:0]             grant_id;
    logic                   bus_cmd_valid;
    logic                   cmd_ready;
    logic                   bus_we;
    logic [ADDR_W-1:0]      bus_addr;
    logic [DATA_W-1:0]      bus_wdata;
    logic                   bus_rsp_valid;
    logic [DATA_W-1:0]      bus_rdata;

    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;

    int total;
    int bad;

    assign req_addr  = {a1, a0};
    assign req_wdata = {d1, d0};

    slot_bus_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)
    ) dut (
        .sys_clk       (clk),
        .sys_rst       (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .grant_id      (grant_id),
        .bus_cmd_valid (bus_cmd_valid),
        .bus_cmd_ready (cmd_ready),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rdata     (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [2:0]        grants [6];
        logic [ADDR_W-1:0] addrs  [6];
        int ngr, overlap, nrdy, nrsp, unstable;
        logic found;
        logic [NREQ-1:0] rv;

        total = 0; bad = 0;
        rst = 1'b1; req_valid = '0; req_we = '0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        cmd_ready = 1'b1; bus_rsp_valid = 1'b0; bus_rdata = '0;

        // 1: reset values, then a lone request from requester 1
        repeat (2) @(posedge clk);
        step();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_err",   32'(rsp_err), 0);
        chk("rst_grant",     32'(grant_id), 0);
        chk("rst_cmd_valid", 32'(bus_cmd_valid), 0);
        chk("rst_bus_fields", 32'({bus_we, bus_addr, bus_wdata} != 0), 0);
        rst = 1'b0;
        req_valid = 2'b10; req_we = 2'b10; a1 = 8'h22; d1 = 16'h1234;
        step();
        chk("first_grant",     32'(grant_id), 1);
        chk("first_req_ready", 32'(req_ready), 'h2);
        chk("first_cmd_valid", 32'(bus_cmd_valid), 1);
        chk("first_addr",      32'(bus_addr), 'h22);
        req_valid = '0;
        step();
        chk("first_rsp_valid", 32'(rsp_valid), 'h2);
        step();

        // 2: write from requester 0
        req_valid = 2'b01; req_we = 2'b01; a0 = 8'h10; d0 = 16'hFFFF;
        step();
        chk("wr_req_ready", 32'(req_ready), 'h1);
        chk("wr_grant",     32'(grant_id), 0);
        chk("wr_bus_we",    32'(bus_we), 1);
        chk("wr_bus_addr",  32'(bus_addr), 'h10);
        chk("wr_bus_wdata", 32'(bus_wdata), 'hFFFF);
        req_valid = '0;
        step();
        chk("wr_rsp_valid", 32'(rsp_valid), 'h1);
        chk("wr_rsp_rdata", 32'(rsp_rdata), 0);
        chk("wr_cmd_drop",  32'(bus_cmd_valid), 0);
        step();
        chk("wr_rsp_pulse", 32'(rsp_valid), 0);

        // 3: read from requester 1, data one cycle after accept
        req_valid = 2'b10; req_we = 2'b00; a1 = 8'h08;
        step();
        chk("rd_req_ready", 32'(req_ready), 'h2);
        chk("rd_bus_we",    32'(bus_we), 0);
        chk("rd_bus_addr",  32'(bus_addr), 'h08);
        req_valid = '0;
        step();
        chk("rd_no_early_rsp", 32'(rsp_valid), 0);
        chk("rd_cmd_drop",     32'(bus_cmd_valid), 0);
        bus_rsp_valid = 1'b1; bus_rdata = 16'hA5A5;
        step();
        chk("rd_rsp_valid", 32'(rsp_valid), 'h2);
        chk("rd_rsp_rdata", 32'(rsp_rdata), 'hA5A5);
        bus_rsp_valid = 1'b0; bus_rdata = '0;
        step();
        chk("rd_rsp_pulse", 32'(rsp_valid), 0);
        chk("rd_rdata_hold", 32'(rsp_rdata), 'hA5A5);
        // stray read data while idle must be ignored
        bus_rsp_valid = 1'b1; bus_rdata = 16'h1111;
        step();
        bus_rsp_valid = 1'b0; bus_rdata = '0;
        chk("stray_rsp_valid", 32'(rsp_valid), 0);
        chk("stray_rdata",     32'(rsp_rdata), 'hA5A5);

        // 4: both requesters held high for six accesses
        for (int k = 0; k < 6; k++) begin grants[k] = 3'd7; addrs[k] = '0; end
        req_valid = 2'b11; req_we = 2'b11;
        a0 = 8'h30; a1 = 8'h31; d0 = 16'h0030; d1 = 16'h0031;
        ngr = 0; overlap = 0;
        for (int c = 0; c < 30 && ngr < 6; c++) begin
            step();
            if ($countones(req_ready) > 1) overlap++;
            if (req_ready != '0) begin
                grants[ngr] = grant_id;
                addrs[ngr]  = bus_addr;
                ngr++;
                if (ngr == 6) req_valid = '0;
            end
        end
        req_valid = '0;
        chk("rr_count",   32'(ngr), 6);
        chk("rr_overlap", 32'(overlap), 0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr_grant%0d", k), 32'(grants[k]), k % 2);
            chk($sformatf("rr_addr%0d", k),  32'(addrs[k]), 'h30 + (k % 2));
        end
        step();
        chk("rr_last_rsp",   32'(rsp_valid), 'h2);
        chk("rr_last_rdata", 32'(rsp_rdata), 0);
        step();

        // 5: command stalled for five cycles
        cmd_ready = 1'b0;
        req_valid = 2'b01; req_we = 2'b01; a0 = 8'h44; d0 = 16'hBEEF;
        nrdy = 0; nrsp = 0; unstable = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            nrdy += $countones(req_ready);
            nrsp += $countones(rsp_valid);
            if (!(bus_cmd_valid && bus_we && bus_addr == 8'h44 && bus_wdata == 16'hBEEF))
                unstable++;
            if (i == 0) req_valid = '0;
        end
        chk("stall_no_rsp", 32'(nrsp), 0);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            nrdy += $countones(req_ready);
            nrsp += $countones(rsp_valid);
        end
        chk("stall_ready_cnt", 32'(nrdy), 1);
        chk("stall_rsp_cnt",   32'(nrsp), 1);
        chk("stall_stable",    32'(unstable), 0);
        chk("stall_cmd_drop",  32'(bus_cmd_valid), 0);

        // 6: read that never gets data back
        req_valid = 2'b10; req_we = 2'b00; a1 = 8'h55;
        step();
        chk("to_req_ready", 32'(req_ready), 'h2);
        chk("to_grant",     32'(grant_id), 1);
        req_valid = '0;
`ifdef ARB_TIMEOUT_EN
        found = 1'b0; rv = '0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (rsp_valid != '0) begin found = 1'b1; rv = rsp_valid; end
        end
        chk("to_seen",      32'(found), 1);
        chk("to_rsp_valid", 32'(rv), 'h2);
        chk("to_rsp_err",   32'(rsp_err), 1);
        chk("to_rsp_rdata", 32'(rsp_rdata), 'hDEAD);
        chk("to_cmd_valid", 32'(bus_cmd_valid), 0);
        req_valid = 2'b01; req_we = 2'b01; a0 = 8'h12; d0 = 16'h0012;
        step();
        chk("to_next_ready", 32'(req_ready), 'h1);
        req_valid = '0;
        step();
        chk("to_next_rsp",   32'(rsp_valid), 'h1);
        chk("to_next_err",   32'(rsp_err), 0);
        chk("to_next_rdata", 32'(rsp_rdata), 0);
        step();
`else
        found = 1'b0; rv = '0; nrsp = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            nrsp += $countones(rsp_valid);
        end
        chk("hang_no_rsp",   32'(nrsp), 0);
        chk("hang_rsp_err",  32'(rsp_err), 0);
        chk("hang_cmd_low",  32'(bus_cmd_valid), 0);
`endif

        // 7: reset in the middle of an access, then pointer restart
        cmd_ready = 1'b0;
        req_valid = 2'b01; req_we = 2'b01; a0 = 8'h66; d0 = 16'h6666;
        step();
        rst = 1'b1; req_valid = '0;
        step();
        chk("mid_rst_cmd_valid", 32'(bus_cmd_valid), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        chk("mid_rst_grant",     32'(grant_id), 0);
        chk("mid_rst_addr",      32'(bus_addr), 0);
        rst = 1'b0; cmd_ready = 1'b1;
        step();
        chk("mid_rst_silent", 32'(rsp_valid), 0);
        req_valid = 2'b11; req_we = 2'b11; a0 = 8'h77; a1 = 8'h78;
        d0 = 16'h0077; d1 = 16'h0078;
        step();
        chk("post_rst_grant", 32'(grant_id), 0);
        chk("post_rst_ready", 32'(req_ready), 'h1);
        chk("post_rst_addr",  32'(bus_addr), 'h77);
        req_valid = '0;
        step();
        chk("post_rst_rsp", 32'(rsp_valid), 'h1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
